// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared pipeline encodings and control-bundle layout
// Used by pipeline_hazard_ctrl (optional stall counter macro: HAZARD_STALL_COUNT_EN).
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam int REG_IDX_W = 5;

   // Control-bundle bit positions, shared with the stage registers
   localparam int CB_PC_WRITE    = 0;
   localparam int CB_IFID_WRITE  = 1;
   localparam int CB_IFID_FLUSH  = 2;
   localparam int CB_IDEX_WRITE  = 3;
   localparam int CB_IDEX_FLUSH  = 4;
   localparam int CB_EXMEM_WRITE = 5;
   localparam int CB_MEMWB_FLUSH = 6;
   localparam int CB_WIDTH       = 7;

   typedef logic [CB_WIDTH-1:0] ctrl_t;

   function automatic ctrl_t ctrl_bundle(
      input logic pc_write,
      input logic ifid_write,
      input logic ifid_flush,
      input logic idex_write,
      input logic idex_flush,
      input logic exmem_write,
      input logic memwb_flush
   );
      ctrl_t c;
      c                 = '0;
      c[CB_PC_WRITE]    = pc_write;
      c[CB_IFID_WRITE]  = ifid_write;
      c[CB_IFID_FLUSH]  = ifid_flush;
      c[CB_IDEX_WRITE]  = idex_write;
      c[CB_IDEX_FLUSH]  = idex_flush;
      c[CB_EXMEM_WRITE] = exmem_write;
      c[CB_MEMWB_FLUSH] = memwb_flush;
      return c;
   endfunction

   localparam ctrl_t CTRL_ADVANCE = ctrl_bundle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
   localparam ctrl_t CTRL_RESET   = ctrl_bundle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
   localparam ctrl_t CTRL_WAIT    = ctrl_bundle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   localparam ctrl_t CTRL_BRANCH  = ctrl_bundle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
   // Hold PC and IF/ID, inject a bubble into EX; shared by load-use and drain
   localparam ctrl_t CTRL_HOLD_ID = ctrl_bundle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
   localparam ctrl_t CTRL_FROZEN  = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect_lu.sv
// rtl/pipeline_hazard_ctrl_hazard_detect_lu.sv - load-use hazard compare between ID and EX
// Purely combinational; sequencing lives in pipeline_hazard_ctrl.
module hazard_detect_lu
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic [REG_IDX_W-1:0] ID_Rs,
   input  logic [REG_IDX_W-1:0] ID_Rt,
   input  logic                 ID_UsesRt,
   input  logic                 EX_MemRead,
   input  logic [REG_IDX_W-1:0] EX_RegDest,
   output logic                 Load_Use
);

   // r0 is hard-wired zero, so a load into it never creates a dependency
   assign Load_Use = EX_MemRead && (EX_RegDest != '0) &&
                     ((EX_RegDest == ID_Rs) || (ID_UsesRt && (EX_RegDest == ID_Rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer with halt/drain/resume and memory timeout
// Optional stall-cycle counter enabled by macro HAZARD_STALL_COUNT_EN.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int MEM_TIMEOUT  = 255
)(
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [REG_IDX_W-1:0] ID_Rs,
   input  logic [REG_IDX_W-1:0] ID_Rt,
   input  logic                 ID_UsesRt,
   input  logic                 EX_MemRead,
   input  logic [REG_IDX_W-1:0] EX_RegDest,
   input  logic                 MEM_MemRead,
   input  logic                 MEM_MemWrite,
   input  logic                 DMem_Ready,
   input  logic                 BranchTaken_EX,
   input  logic                 Halt_Req,
   input  logic                 Resume,
`ifdef HAZARD_STALL_COUNT_EN
   input  logic                 Stall_Clear,
   output logic [31:0]          Stall_Cycles,
`endif
   output logic                 PC_Write,
   output logic                 IFID_Write,
   output logic                 IFID_Flush,
   output logic                 IDEX_Write,
   output logic                 IDEX_Flush,
   output logic                 EXMEM_Write,
   output logic                 MEMWB_Flush,
   output logic                 Halted,
   output logic                 Mem_Error
);

   localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);
   localparam logic [7:0] TIMEOUT_V  = 8'(MEM_TIMEOUT);

   state_t     state, state_next;
   logic [2:0] drain_cnt, drain_next;
   logic [7:0] wait_cnt, wait_next;
   logic       mem_wait, load_use, halted_c;
   ctrl_t      ctrl;

   hazard_detect_lu u_lu (
      .ID_Rs      (ID_Rs),
      .ID_Rt      (ID_Rt),
      .ID_UsesRt  (ID_UsesRt),
      .EX_MemRead (EX_MemRead),
      .EX_RegDest (EX_RegDest),
      .Load_Use   (load_use)
   );

   // A frozen, drained pipeline does not react to memory wait
   assign mem_wait = (MEM_MemRead || MEM_MemWrite) && !DMem_Ready && (state != HALTED);

   always_comb begin
      ctrl       = CTRL_ADVANCE;
      state_next = state;
      drain_next = drain_cnt;
      halted_c   = 1'b0;
      if (mem_wait)
         wait_next = (wait_cnt >= TIMEOUT_V) ? TIMEOUT_V : wait_cnt + 8'd1;
      else
         wait_next = 8'd0;

      if (Reset) begin
         ctrl = CTRL_RESET;
      end else begin
         case (state)
            RUN: begin
               if (mem_wait) begin
                  ctrl = CTRL_WAIT;
               end else if (BranchTaken_EX) begin
                  ctrl = CTRL_BRANCH;
               end else begin
                  if (load_use)
                     ctrl = CTRL_HOLD_ID;
                  if (Halt_Req) begin
                     state_next = DRAIN;
                     drain_next = DRAIN_INIT;
                  end
               end
            end
            DRAIN: begin
               if (mem_wait) begin
                  ctrl = CTRL_WAIT;
               end else begin
                  ctrl = BranchTaken_EX ? CTRL_BRANCH : CTRL_HOLD_ID;
                  if (drain_cnt == 3'd0)
                     state_next = HALTED;
                  else
                     drain_next = drain_cnt - 3'd1;
               end
            end
            HALTED: begin
               ctrl     = CTRL_FROZEN;
               halted_c = 1'b1;
               if (Resume)
                  state_next = RUN;
            end
            default: state_next = RUN;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= RUN;
         drain_cnt <= 3'd0;
         wait_cnt  <= 8'd0;
         Mem_Error <= 1'b0;
      end else begin
         state     <= state_next;
         drain_cnt <= drain_next;
         wait_cnt  <= wait_next;
         if (mem_wait && (wait_next == TIMEOUT_V))
            Mem_Error <= 1'b1;
      end
   end

`ifdef HAZARD_STALL_COUNT_EN
   always_ff @(posedge Clock) begin
      if (Reset || Stall_Clear)
         Stall_Cycles <= 32'd0;
      else if (!ctrl[CB_PC_WRITE] && (state != HALTED))
         Stall_Cycles <= Stall_Cycles + 32'd1;
   end
`endif

   assign PC_Write    = ctrl[CB_PC_WRITE];
   assign IFID_Write  = ctrl[CB_IFID_WRITE];
   assign IFID_Flush  = ctrl[CB_IFID_FLUSH];
   assign IDEX_Write  = ctrl[CB_IDEX_WRITE];
   assign IDEX_Flush  = ctrl[CB_IDEX_FLUSH];
   assign EXMEM_Write = ctrl[CB_EXMEM_WRITE];
   assign MEMWB_Flush = ctrl[CB_MEMWB_FLUSH];
   assign Halted      = halted_c;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives per-stage write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards, taken-branch flushes and data-memory wait states.
- Sequences a halt/drain/resume handshake and flags data-memory timeouts.

Parameters:
- DRAIN_CYCLES, 3, cycles of bubble injection needed to empty EX, MEM and WB after a halt; legal range 1-7.
- MEM_TIMEOUT, 255, consecutive memory-wait cycles before Mem_Error sets; legal range 1-255.

Ports:
- Clock  in  1  pipeline clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high reset.
- ID_Rs  in  5  source register rs of the instruction in ID.
- ID_Rt  in  5  source register rt of the instruction in ID.
- ID_UsesRt  in  1  ID instruction reads rt.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_RegDest  in  5  destination register of the instruction in EX.
- MEM_MemRead  in  1  MEM stage is issuing a load.
- MEM_MemWrite  in  1  MEM stage is issuing a store.
- DMem_Ready  in  1  data memory completes the access this cycle.
- BranchTaken_EX  in  1  taken branch or jump resolved in EX.
- Halt_Req  in  1  debug halt request, level.
- Resume  in  1  one-cycle pulse; leave HALTED.
- PC_Write  out  1  PC register enable.
- IFID_Write  out  1  IF/ID register enable.
- IFID_Flush  out  1  IF/ID loads a bubble.
- IDEX_Write  out  1  ID/EX register enable.
- IDEX_Flush  out  1  ID/EX loads a bubble.
- EXMEM_Write  out  1  EX/MEM register enable.
- MEMWB_Flush  out  1  MEM/WB loads a bubble.
- Halted  out  1  pipeline is drained and frozen.
- Mem_Error  out  1  sticky memory-timeout flag.

Behaviour:
- Reset values: state=RUN, drain counter=0, wait counter=0, Mem_Error=0, Halted=0.
- During Reset: PC_Write, IFID_Write, IDEX_Write and EXMEM_Write = 0; all flush outputs = 1.
- Outputs are combinational from state and inputs (zero latency); only state and counters are registered.
- Conditions:
  - W = (MEM_MemRead | MEM_MemWrite) & ~DMem_Ready.
  - LU = EX_MemRead & EX_RegDest≠0 & (EX_RegDest==ID_Rs | (ID_UsesRt & EX_RegDest==ID_Rt)).
- Default (advance): all write enables = 1, all flushes = 0.
- Priority in RUN and DRAIN: W > BranchTaken_EX > LU > Halt.
- W (any state except HALTED):
  - All write enables = 0, MEMWB_Flush = 1.
  - Wait counter increments, saturating at MEM_TIMEOUT; state and drain counter are frozen.
  - When the wait counter reaches MEM_TIMEOUT, Mem_Error=1 until Reset; stalling continues.
  - Wait counter clears on any cycle with W=0.
- BranchTaken_EX without W: PC_Write=1, IFID_Flush=1, IDEX_Flush=1.
- LU without W or branch: PC_Write=0, IFID_Write=0, IDEX_Flush=1. This is a one-cycle bubble; the hazard clears naturally next cycle.
- RUN:
  - Halt_Req=1 with W=0 and BranchTaken_EX=0 -> next state DRAIN, drain counter=DRAIN_CYCLES-1.
  - The LU response applies in that same cycle if LU is true.
- DRAIN:
  - PC_Write=0, IFID_Write=0, IDEX_Flush=1. The ID instruction is preserved; bubbles enter EX.
  - BranchTaken_EX in DRAIN: PC_Write=1, IFID_Flush=1 (target fetched on resume).
  - Drain counter decrements per non-W cycle. At 0 -> HALTED.
  - Halt_Req deasserting in DRAIN does not abort the drain.
- HALTED:
  - All write enables = 0, all flushes = 0, Halted=1. W is ignored.
  - Resume=1 -> RUN next cycle; Halted=0 from that cycle.
  - Resume is ignored in RUN and DRAIN.
  - Halt_Req still high when RUN is re-entered re-triggers DRAIN.
- Reset mid-wait or mid-drain: returns to RUN immediately; Mem_Error cleared.

Optional Feature:
- Macro: HAZARD_STALL_COUNT_EN.
- Defined:
  - Adds output Stall_Cycles [31:0] and input Stall_Clear [1].
  - Stall_Cycles increments each cycle PC_Write=0 in RUN or DRAIN, wraps at 2^32, and clears on Reset or Stall_Clear. Stall_Clear wins over an increment in the same cycle.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared pipeline package:
  - State encoding constants: RUN=2'd0, DRAIN=2'd1, HALTED=2'd2.
  - Register-index width constant (5).
  - Control-bundle bit positions, reused by the stage registers.
- One natural sub-module, hazard_detect_lu: combinational LU compare. All sequencing stays in the parent.

Test Plan:
- EX_MemRead=1, EX_RegDest=8, ID_Rs=8 -> one cycle of PC_Write=0, IFID_Write=0, IDEX_Flush=1; next cycle advance.
- Same as above with EX_RegDest=0 -> no stall. Same with ID_Rt=8 and ID_UsesRt=0 -> no stall.
- BranchTaken_EX=1 together with LU true -> PC_Write=1, IFID_Flush=1, IDEX_Flush=1 (branch wins).
- MEM_MemRead=1 with DMem_Ready=0 for 4 cycles -> all write enables 0 and MEMWB_Flush=1 for 4 cycles; advance on the cycle DMem_Ready=1.
- MEM_TIMEOUT=3 with DMem_Ready held at 0 -> Mem_Error rises after the 3rd wait cycle and stays 1 after DMem_Ready=1, until Reset.
- Halt_Req pulsed with DRAIN_CYCLES=3 and one W cycle inside the drain:
  - Halted rises 4 cycles after DRAIN entry; ID instruction held throughout.
  - Resume -> RUN next cycle with Halted=0.
